// File: rtl/sobel_frame_controller.sv
// Frame sequencer for the Sobel datapath: walks the output window over the frame and
// handshakes with the read/shift/calc/write/move units. Optional watchdog: CTRL_TIMEOUT_EN.
module sobel_frame_controller #(
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int KERNEL      = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     read_done,
    input  logic                     shift_done,
    input  logic                     calculation_done,
    input  logic                     write_done,
    input  logic                     move_done,
    output logic                     start_read,
    output logic                     start_shift,
    output logic                     start_calculation,
    output logic                     start_write,
    output logic                     start_move,
    output logic                     busy,
    output logic                     frame_done,
    output logic [$clog2(IMG_H)-1:0] row_idx,
    output logic [$clog2(IMG_W)-1:0] col_idx,
    output logic                     err
);
    localparam int OUT_ROWS = IMG_H - KERNEL + 1;
    localparam int OUT_COLS = IMG_W - KERNEL + 1;
    localparam int RW       = $clog2(IMG_H);
    localparam int CW       = $clog2(IMG_W);
    localparam int PW       = $clog2(KERNEL + 1);

    typedef enum logic [3:0] {
        IDLE, RD, RD_W, SH, SH_W, CA, CA_W, WR, WR_W, MV, MV_W, DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] prime_cnt;

`ifdef CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wait_cnt;
    logic          in_wait;
    logic          wait_hit;

    always_comb begin
        in_wait  = 1'b1;
        wait_hit = 1'b0;
        case (state)
            RD_W:    wait_hit = read_done;
            SH_W:    wait_hit = shift_done;
            CA_W:    wait_hit = calculation_done;
            WR_W:    wait_hit = write_done;
            MV_W:    wait_hit = move_done;
            default: in_wait  = 1'b0;
        endcase
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            row_idx   <= '0;
            col_idx   <= '0;
            prime_cnt <= '0;
`ifdef CTRL_TIMEOUT_EN
            wait_cnt  <= '0;
            err       <= 1'b0;
`endif
        end else begin
`ifdef CTRL_TIMEOUT_EN
            // Issue states always precede a wait state, so the count restarts on entry.
            wait_cnt <= in_wait ? wait_cnt + 1'b1 : '0;
`endif
            if (abort && state != IDLE) begin
                state     <= IDLE;
                row_idx   <= '0;
                col_idx   <= '0;
                prime_cnt <= '0;
`ifdef CTRL_TIMEOUT_EN
            end else if (in_wait && !wait_hit && wait_cnt == TW'(TIMEOUT_CYC - 1)) begin
                state     <= IDLE;
                err       <= 1'b1;
                row_idx   <= '0;
                col_idx   <= '0;
                prime_cnt <= '0;
`endif
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state     <= RD;
                        row_idx   <= '0;
                        col_idx   <= '0;
                        prime_cnt <= '0;
`ifdef CTRL_TIMEOUT_EN
                        err       <= 1'b0;
`endif
                    end
                    RD:   state <= RD_W;
                    RD_W: if (read_done) begin
                        // Row 0 primes the line buffer with KERNEL reads; later rows need one.
                        if (row_idx == RW'(0)) begin
                            prime_cnt <= prime_cnt + 1'b1;
                            state     <= (prime_cnt < PW'(KERNEL - 1)) ? RD : SH;
                        end else begin
                            state <= SH;
                        end
                    end
                    SH:   state <= SH_W;
                    SH_W: if (shift_done) state <= CA;
                    CA:   state <= CA_W;
                    CA_W: if (calculation_done) state <= WR;
                    WR:   state <= WR_W;
                    WR_W: if (write_done) begin
                        if (col_idx < CW'(OUT_COLS - 1)) begin
                            col_idx <= col_idx + 1'b1;
                            state   <= SH;
                        end else begin
                            col_idx <= '0;
                            state   <= (row_idx < RW'(OUT_ROWS - 1)) ? MV : DONE;
                        end
                    end
                    MV:   state <= MV_W;
                    MV_W: if (move_done) begin
                        row_idx <= row_idx + 1'b1;
                        state   <= RD;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Pulses are suppressed in the abort cycle so an aborted issue never reaches a unit.
    assign start_read        = (state == RD)   && !abort;
    assign start_shift       = (state == SH)   && !abort;
    assign start_calculation = (state == CA)   && !abort;
    assign start_write       = (state == WR)   && !abort;
    assign start_move        = (state == MV)   && !abort;
    assign frame_done        = (state == DONE) && !abort;
    assign busy              = (state != IDLE);
endmodule

// File: tb/tb_sobel_frame_controller.sv
// Scoreboard bench for sobel_frame_controller: randomized unit latencies and stray done
// pulses, checked against an event sequence derived from the frame geometry.
module tb_sobel_frame_controller;
    localparam int IMG_W    = 5;
    localparam int IMG_H    = 4;
    localparam int KERNEL   = 3;
    localparam int TO_CYC   = 8;
    localparam int OUT_ROWS = IMG_H - KERNEL + 1;
    localparam int OUT_COLS = IMG_W - KERNEL + 1;
    localparam int K_RD = 0, K_SH = 1, K_CA = 2, K_WR = 3, K_MV = 4, K_FD = 5;

    logic clk = 1'b0, n_rst = 1'b0, start = 1'b0, abort = 1'b0;
    logic [4:0] done_vec = '0;
    logic read_done, shift_done, calculation_done, write_done, move_done;
    logic start_read, start_shift, start_calculation, start_write, start_move;
    logic busy, frame_done, err;
    logic [$clog2(IMG_H)-1:0] row_idx;
    logic [$clog2(IMG_W)-1:0] col_idx;

    assign {move_done, write_done, calculation_done, shift_done, read_done} = done_vec;

    sobel_frame_controller #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .KERNEL(KERNEL), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .read_done(read_done), .shift_done(shift_done),
        .calculation_done(calculation_done), .write_done(write_done),
        .move_done(move_done), .start_read(start_read), .start_shift(start_shift),
        .start_calculation(start_calculation), .start_write(start_write),
        .start_move(start_move), .busy(busy), .frame_done(frame_done),
        .row_idx(row_idx), .col_idx(col_idx), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { int kind; int row; int col; } ev_t;
    ev_t  exp_q[$];
    int   tests = 0, fails = 0, frames_seen = 0;
    int   seen[6];
    logic hold = 1'b0;

    function automatic void check(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    function automatic logic [5:0] pulses();
        return {frame_done, start_move, start_write, start_calculation, start_shift, start_read};
    endfunction

    // Expected pulse sequence for one frame, straight from the window-walk rules.
    task automatic push_frame();
        for (int r = 0; r < OUT_ROWS; r++) begin
            for (int k = 0; k < ((r == 0) ? KERNEL : 1); k++) exp_q.push_back('{K_RD, r, 0});
            for (int c = 0; c < OUT_COLS; c++) begin
                exp_q.push_back('{K_SH, r, c});
                exp_q.push_back('{K_CA, r, c});
                exp_q.push_back('{K_WR, r, c});
            end
            if (r < OUT_ROWS - 1) exp_q.push_back('{K_MV, r, 0});
        end
        exp_q.push_back('{K_FD, OUT_ROWS - 1, 0});
    endtask

    // Monitor: pops one expected event per observed pulse.
    logic [5:0] mon_p;
    int         mon_k;
    ev_t        mon_e;
    always @(negedge clk) begin
        if (n_rst) begin
            mon_p = pulses();
            if ($countones(mon_p) > 1) check("one_hot_pulses", $countones(mon_p), 1);
            if (frame_done && !busy) check("busy_at_frame_done", busy, 1);
`ifndef CTRL_TIMEOUT_EN
            if (err) check("err_tied_low", err, 0);
`endif
            if ($countones(mon_p) == 1) begin
                mon_k = 0;
                for (int i = 0; i < 6; i++) if (mon_p[i]) mon_k = i;
                seen[mon_k]++;
                if (mon_k == K_FD) frames_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", mon_k, -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_kind", mon_k, mon_e.kind);
                    check("pulse_row", int'(row_idx), mon_e.row);
                    check("pulse_col", int'(col_idx), mon_e.col);
                end
            end
        end
    end

    // Downstream units: answer the pending start after 1..3 cycles, with stray done
    // pulses on the other units' lines to exercise wrong-state rejection.
    int         r_pend = -1, r_cnt = 0;
    logic [4:0] r_dv;
    initial begin
        forever begin
            @(posedge clk); #1;
            r_dv = '0;
            if (r_pend >= 0 && !hold) begin
                if (r_cnt <= 1) begin
                    r_dv[r_pend] = 1'b1;
                    r_pend = -1;
                end else r_cnt--;
            end
            for (int i = 0; i < 5; i++)
                if (i != r_pend && $urandom_range(0, 3) == 0) r_dv[i] = 1'b1;
            done_vec = r_dv;
            @(negedge clk);
            if (!busy) r_pend = -1;
            else begin
                for (int i = 0; i < 5; i++)
                    if (pulses()[i]) begin
                        r_pend = i;
                        r_cnt  = int'($urandom_range(1, 3));
                    end
            end
        end
    end

    task automatic begin_frame();
        push_frame();
        @(posedge clk); #1 start = 1'b1;
        @(negedge clk); #1;
        check("start_read_before", start_read, 0);
        check("busy_before", busy, 0);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk); #1;
        check("start_read_next_cycle", start_read, 1);
        check("busy_next_cycle", busy, 1);
    endtask

    task automatic run_frame();
        int s0[6];
        int f0, low, got;
        for (int i = 0; i < 6; i++) s0[i] = seen[i];
        f0 = frames_seen; low = 0; got = 0;
        begin_frame();
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge clk); #1;
            if (frames_seen > f0) got = 1;
            else if (!busy) low++;
        end
        check("frame_completed", got, 1);
        check("busy_gap_cycles", low, 0);
        check("queue_empty", exp_q.size(), 0);
        check("cnt_read", seen[K_RD] - s0[K_RD], KERNEL + OUT_ROWS - 1);
        check("cnt_shift", seen[K_SH] - s0[K_SH], OUT_ROWS * OUT_COLS);
        check("cnt_calc", seen[K_CA] - s0[K_CA], OUT_ROWS * OUT_COLS);
        check("cnt_write", seen[K_WR] - s0[K_WR], OUT_ROWS * OUT_COLS);
        check("cnt_move", seen[K_MV] - s0[K_MV], OUT_ROWS - 1);
        check("cnt_frame_done", seen[K_FD] - s0[K_FD], 1);
        @(negedge clk); #1;
        check("busy_after_frame", busy, 0);
    endtask

    task automatic wait_for(input int kind, input int row, input int col);
        int found = 0;
        for (int n = 0; n < 3000 && !found; n++) begin
            @(negedge clk); #1;
            if (pulses()[kind] && int'(row_idx) == row && int'(col_idx) == col) found = 1;
        end
        check("target_pulse_found", found, 1);
        hold = 1'b1;
    endtask

    int f_snap;
    initial begin
        for (int i = 0; i < 6; i++) seen[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pulses", int'(pulses()), 0);
        check("reset_busy", busy, 0);
        check("reset_idx", int'({row_idx, col_idx}), 0);
        check("reset_err", err, 0);
        n_rst = 1'b1;

        repeat (3) run_frame();

        // Abort while waiting on the shift unit at row 1, column 2.
        f_snap = frames_seen;
        begin_frame();
        wait_for(K_SH, 1, 2);
        @(posedge clk); #1 abort = 1'b1;
        @(negedge clk); #1;
        check("abort_wait_busy", busy, 1);
        @(posedge clk); #1 abort = 1'b0;
        exp_q.delete();
        @(negedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_row", int'(row_idx), 0);
        check("abort_col", int'(col_idx), 0);
        check("abort_frame_done", frames_seen - f_snap, 0);
        hold = 1'b0;
        run_frame();

        // Asynchronous reset while waiting on the write unit.
        begin_frame();
        wait_for(K_WR, 1, 1);
        @(posedge clk); #2 n_rst = 1'b0;
        #1;
        check("rst_pulses", int'(pulses()), 0);
        check("rst_busy", busy, 0);
        check("rst_idx", int'({row_idx, col_idx}), 0);
        exp_q.delete();
        hold = 1'b0;
        @(posedge clk); #1 n_rst = 1'b1;
        run_frame();

`ifdef CTRL_TIMEOUT_EN
        // Withhold move_done: watchdog fires after TO_CYC cycles in MV_W.
        f_snap = frames_seen;
        begin_frame();
        wait_for(K_MV, 0, 0);
        begin
            int hi = 0;
            for (int n = 0; n < TO_CYC; n++) begin
                @(negedge clk); #1;
                if (busy) hi++;
            end
            check("to_wait_cycles", hi, TO_CYC);
        end
        @(negedge clk); #1;
        check("to_busy", busy, 0);
        check("to_err", err, 1);
        check("to_frame_done", frames_seen - f_snap, 0);
        exp_q.delete();
        hold = 1'b0;
        run_frame();
        check("err_cleared_by_start", err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
